// File: rtl/demod_pkg.sv
// Shared constants, state encoding and helpers for the hard-decision demapper.
package demod_pkg;

  localparam int W_DEF      = 12;
  localparam int TH16_DEF   = 162;
  localparam int TH64_A_DEF = 80;
  localparam int TH64_B_DEF = 158;
  localparam int TH64_C_DEF = 237;

  localparam logic [1:0] MOD_BPSK  = 2'd0;
  localparam logic [1:0] MOD_QPSK  = 2'd1;
  localparam logic [1:0] MOD_16QAM = 2'd2;
  localparam logic [1:0] MOD_64QAM = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic logic [2:0] bits_per_sym(input logic [1:0] mode);
    case (mode)
      MOD_BPSK:  return 3'd1;
      MOD_QPSK:  return 3'd2;
      MOD_16QAM: return 3'd4;
      default:   return 3'd6;
    endcase
  endfunction

endpackage

// File: rtl/demod_slicer.sv
// Single-axis hard slicer: sign plus magnitude-threshold decisions,
// MSB-aligned into a 3-bit Gray-coded axis decision.
module demod_slicer
  import demod_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int TH16   = TH16_DEF,
  parameter int TH64_A = TH64_A_DEF,
  parameter int TH64_B = TH64_B_DEF,
  parameter int TH64_C = TH64_C_DEF
) (
  input  logic [W-1:0] x_i,
  input  logic [1:0]   mode_i,
  output logic [2:0]   dec_o
);

  localparam logic [W-1:0] TH16_V   = W'(TH16);
  localparam logic [W-1:0] TH64_A_V = W'(TH64_A);
  localparam logic [W-1:0] TH64_B_V = W'(TH64_B);
  localparam logic [W-1:0] TH64_C_V = W'(TH64_C);
  localparam logic [W-1:0] NEG_MAX  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] POS_MAX  = {1'b0, {(W-1){1'b1}}};

  logic         sign;
  logic [W-1:0] mag;

  // Zero slices as positive; the most negative code saturates instead of wrapping.
  assign sign = ~x_i[W-1];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    mag = x_i;
    if (x_i[W-1]) begin
      mag = (x_i == NEG_MAX) ? POS_MAX : -x_i;
    end
  end

  always_comb begin
    dec_o = {sign, 2'b00};
    case (mode_i)
      MOD_16QAM: dec_o = {sign, mag < TH16_V, 1'b0};
      MOD_64QAM: dec_o = {sign, mag < TH64_B_V, (mag >= TH64_A_V) & (mag < TH64_C_V)};
      default:   dec_o = {sign, 2'b00};
    endcase
  end

endmodule

// File: rtl/digital_demodulator.sv
// Hard-decision BPSK/QPSK/16QAM/64QAM demapper emitting recovered bits serially.
// Define DEMOD_DROP_CNT_EN to add o_drop_cnt, a saturating count of refused samples.
module digital_demodulator
  import demod_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int TH16   = TH16_DEF,
  parameter int TH64_A = TH64_A_DEF,
  parameter int TH64_B = TH64_B_DEF,
  parameter int TH64_C = TH64_C_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_in_vld,
  input  logic [W-1:0] i_i,
  input  logic [W-1:0] i_q,
  input  logic [1:0]   i_mod,
  output logic         o_ready,
  output logic         o_data_vld,
  output logic         o_data,
`ifdef DEMOD_DROP_CNT_EN
  output logic [15:0]  o_drop_cnt,
`endif
  output logic         o_sym_start
);

  state_e     state_q;
  logic [2:0] cnt_q;
  logic [5:0] sr_q;
  logic       data_q;
  logic       vld_q;
  logic       start_q;

  logic [2:0] dec_i;
  logic [2:0] dec_q;
  logic [5:0] sym;
  logic       accept;

  demod_slicer #(
    .W(W), .TH16(TH16), .TH64_A(TH64_A), .TH64_B(TH64_B), .TH64_C(TH64_C)
  ) u_slicer_i (
    .x_i    (i_i),
    .mode_i (i_mod),
    .dec_o  (dec_i)
  );

  demod_slicer #(
    .W(W), .TH16(TH16), .TH64_A(TH64_A), .TH64_B(TH64_B), .TH64_C(TH64_C)
  ) u_slicer_q (
    .x_i    (i_q),
    .mode_i (i_mod),
    .dec_o  (dec_q)
  );

  // A new symbol can load on the same edge the previous one's last bit leaves.
  assign o_ready = i_en & ((state_q == IDLE) | ((state_q == SHIFT) & (cnt_q == 3'd0)));
  assign accept  = i_in_vld & o_ready;

  always_comb begin
    sym = '0;
    case (i_mod)
      MOD_BPSK:  sym = {dec_i[2], 5'b0};
      MOD_QPSK:  sym = {dec_i[2], dec_q[2], 4'b0};
      MOD_16QAM: sym = {dec_i[2:1], dec_q[2:1], 2'b0};
      default:   sym = {dec_i, dec_q};
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the shift register is reset too, so a cut-short symbol leaves no stale bits behind.
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      data_q  <= 1'b0;
      vld_q   <= 1'b0;
      start_q <= 1'b0;
    end else if (accept) begin
      state_q <= SHIFT;
      cnt_q   <= bits_per_sym(i_mod) - 3'd1;
      sr_q    <= {sym[4:0], 1'b0};
      data_q  <= sym[5];
      vld_q   <= 1'b1;
      start_q <= 1'b1;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: vld_q <= 1'b0;
        SHIFT: begin
          if (cnt_q != 3'd0) begin
            data_q <= sr_q[5];
            sr_q   <= {sr_q[4:0], 1'b0};
            cnt_q  <= cnt_q - 3'd1;
            vld_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_data_vld  = vld_q;
  assign o_sym_start = start_q;

`ifdef DEMOD_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      drop_cnt_q <= '0;
    end else if (i_in_vld && !o_ready && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_digital_demodulator.sv
// Scoreboard bench for digital_demodulator: a region/Gray-table reference model
// queues expected bits at issue time, a negedge monitor pops and compares them.
module tb_digital_demodulator;
  import demod_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        in_vld = 1'b0;
  logic [11:0] si = '0;
  logic [11:0] sq = '0;
  logic [1:0]  smod = '0;
  logic        ready, data_vld, data, sym_start;
`ifdef DEMOD_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  digital_demodulator dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_in_vld    (in_vld),
    .i_i         (si),
    .i_q         (sq),
    .i_mod       (smod),
    .o_ready     (ready),
    .o_data_vld  (data_vld),
    .o_data      (data),
`ifdef DEMOD_DROP_CNT_EN
    .o_drop_cnt  (drop_cnt),
`endif
    .o_sym_start (sym_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit d;
    bit st;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sign, then magnitude region index mapped through the Gray level table.
  function automatic logic [2:0] ref_axis(input int x, input logic [1:0] m);
    int       mag;
    int       region;
    logic     s;
    logic [1:0] gray [4];
    gray = '{2'b10, 2'b11, 2'b01, 2'b00};
    s = (x >= 0) ? 1'b1 : 1'b0;
    mag = (x < 0) ? -x : x;
    if (mag > 2047) mag = 2047;
    region = 0;
    if (m == MOD_16QAM) begin
      if (mag >= 162) region = 1;
      return {s, (region == 0) ? 1'b1 : 1'b0, 1'b0};
    end
    if (m == MOD_64QAM) begin
      if (mag >= 80)  region = 1;
      if (mag >= 158) region = 2;
      if (mag >= 237) region = 3;
      return {s, gray[region]};
    end
    return {s, 2'b00};
  endfunction

  task automatic push_sym(input logic [1:0] m, input int iv, input int qv);
    logic [2:0] a;
    logic [2:0] b;
    bit         bits[$];
    a = ref_axis(iv, m);
    b = ref_axis(qv, m);
    bits.push_back(a[2]);
    if (m != MOD_BPSK) begin
      if (m == MOD_64QAM) begin
        bits.push_back(a[1]); bits.push_back(a[0]);
        bits.push_back(b[2]); bits.push_back(b[1]); bits.push_back(b[0]);
      end else if (m == MOD_16QAM) begin
        bits.push_back(a[1]); bits.push_back(b[2]); bits.push_back(b[1]);
      end else begin
        bits.push_back(b[2]);
      end
    end
    foreach (bits[k]) sb.push_back('{d: bits[k], st: (k == 0)});
  endtask

  // Waits (bounded) for o_ready at a falling edge, then presents one symbol across the next rising edge.
  task automatic send(input logic [1:0] m, input int iv, input int qv, output int waited);
    waited = 0;
    @(negedge clk);
    while (!ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready stayed %0b, required 1", ready);
    end else begin
      smod = m;
      si = 12'(iv);
      sq = 12'(qv);
      push_sym(m, iv, qv);
      in_vld = 1'b1;
      @(posedge clk);
      #1 in_vld = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check(name, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && data_vld) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bit: got bit %0b, required no output", data);
      end else begin
        e = sb.pop_front();
        check("bit", data, e.d);
        check("sym_start", sym_start, e.st);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int pts[8];
    int bpsk_vals[4];
    int v;
`ifdef DEMOD_DROP_CNT_EN
    logic [15:0] drop_before;
`endif
    pts = '{256, 181, 81, 243, 40, 119, 197, 277};
    bpsk_vals = '{256, -256, 0, 256};

    // Reset state
    #12;
    check("rst_data_vld", data_vld, 0);
    check("rst_data", data, 0);
    check("rst_sym_start", sym_start, 0);
    check("rst_ready", ready, 1);
    en = 1'b0;
    #1 check("ready_en_low_idle", ready, 0);
    en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: QPSK single symbol
    send(MOD_QPSK, 181, -181, w);
    @(negedge clk);
    check("qpsk_busy_ready", ready, 0);
    drain("t1_drain");
    check("t1_ready_after", ready, 1);

    // Test 2: 16QAM
    send(MOD_16QAM, -81, 243, w);
    drain("t2_drain");

    // Test 3: 64QAM plus threshold boundaries
    send(MOD_64QAM, 119, -277, w);
    drain("t3a_drain");
    send(MOD_64QAM, 80, -2048, w);
    drain("t3b_drain");
    send(MOD_64QAM, 0, -158, w);
    drain("t3c_drain");
    send(MOD_64QAM, 237, -79, w);
    drain("t3d_drain");

    // Test 4: back-to-back BPSK stream with no bubble
    foreach (bpsk_vals[k]) begin
      send(MOD_BPSK, bpsk_vals[k], -256, w);
      if (k > 0) begin
        check("bpsk_no_wait", w, 0);
        check("bpsk_no_gap", data_vld, 1);
      end
    end
    drain("t4_drain");

    // Test 5: sample offered while busy is ignored
`ifdef DEMOD_DROP_CNT_EN
    drop_before = drop_cnt;
`endif
    send(MOD_16QAM, 243, -81, w);
    @(negedge clk);
    smod = MOD_BPSK;
    si = 12'(-256);
    sq = 12'(256);
    in_vld = 1'b1;
    @(posedge clk);
    #1 in_vld = 1'b0;
`ifdef DEMOD_DROP_CNT_EN
    check("drop_cnt", drop_cnt, 32'(drop_before) + 1);
`endif
    drain("t5_drain");

    // Enable dropped mid-symbol: symbol completes, then nothing more is accepted
    send(MOD_64QAM, -197, 40, w);
    en = 1'b0;
    drain("en_low_drain");
    in_vld = 1'b1;
    repeat (3) @(negedge clk);
    check("en_low_ready", ready, 0);
    in_vld = 1'b0;
    en = 1'b1;

    // Test 6: reset after the 2nd bit of a 64QAM symbol
    send(MOD_64QAM, 119, -277, w);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_vld", data_vld, 0);
    check("rst_mid_start", sym_start, 0);
    check("rst_mid_data", data, 0);
    check("rst_mid_left", sb.size(), 4);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_release_ready", ready, 1);
    send(MOD_QPSK, -181, 181, w);
    drain("t6_drain");

    // Randomized symbols: constellation points with noise, and full-range samples
    for (int n = 0; n < 80; n++) begin
      int iv;
      int qv;
      logic [1:0] m;
      m = 2'($urandom_range(0, 3));
      for (int a = 0; a < 2; a++) begin
        if ($urandom_range(0, 1) == 1) begin
          v = pts[$urandom_range(0, 7)] + $urandom_range(0, 60) - 30;
          if ($urandom_range(0, 1) == 1) v = -v;
        end else begin
          v = $urandom_range(0, 4095) - 2048;
        end
        if (a == 0) iv = v; else qv = v;
      end
      send(m, iv, qv, w);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
